apb_downsizer: RTL and testbench
================================

# apb_downsizer

Parametrised APB bridge that connects a wide APB master segment to a narrower APB slave segment. Each master transfer is split into RATIO = DATAM_WIDTH/DATAS_WIDTH sequential slave transfers. Read data is reassembled, write beats with no strobes are skipped, and PSLVERR is merged across beats. It replaces the fixed equal-width converter wherever a 32/64-bit peripheral bus feeds 8/16-bit register blocks.

## Interface
- ADDR_WIDTH, 13, address width on both sides (byte address)
- DATAM_WIDTH, 32, master data width; multiple of DATAS_WIDTH, power of two
- DATAS_WIDTH, 8, slave data width; at least 8, power of two
- RATIO (localparam), DATAM_WIDTH/DATAS_WIDTH; RATIO=1 is legal
- PCLK  in  1  clock; all logic is on the rising edge
- PRESET  in  1  asynchronous, active-high reset
- m_psel, m_penable, m_pwrite  in  1 each  master-side APB control
- m_paddr  in  ADDR_WIDTH  master address
- m_pwdata  in  DATAM_WIDTH  write data
- m_pstrb  in  DATAM_WIDTH/8  write byte strobes
- m_prdata  out  DATAM_WIDTH  assembled read data
- m_pready, m_pslverr  out  1 each  master completion and error
- s_psel, s_penable, s_pwrite  out  1 each  slave-side APB control
- s_paddr  out  ADDR_WIDTH  beat address
- s_pwdata  out  DATAS_WIDTH  beat write data
- s_pstrb  out  DATAS_WIDTH/8  beat strobes
- s_prdata  in  DATAS_WIDTH  beat read data
- s_pready, s_pslverr  in  1 each  slave completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On m_psel & ~m_penable, capture paddr, pwdata, pstrb and pwrite.
  - The base address is m_paddr with the low log2(DATAM_WIDTH/8) bits forced to 0.
  - Clear the read buffer and the error accumulator.
  - Go to SETUP with the first beat index. If the transfer is a write and no beat has a nonzero strobe slice, go to DONE instead.
- Beat k:
  - s_paddr = base + k*(DATAS_WIDTH/8).
  - Lane order is big-endian: beat k carries bits [DATAM_WIDTH-1-k*DATAS_WIDTH -: DATAS_WIDTH], and likewise for the strobe slice. Beat 0 (lowest address) is the most-significant slice.
- SETUP: s_psel=1, s_penable=0. Go to ACCESS on the next cycle.
- ACCESS:
  - s_psel=1, s_penable=1. Hold until s_pready=1.
  - On s_pready, store s_prdata into slice k (reads only) and OR s_pslverr into the accumulator.
  - Go to SETUP for the next beat, or to DONE if k was the last beat.
- Write beat skipping:
  - The next beat is the lowest index above k whose strobe slice is nonzero.
  - The search is combinational and costs no cycles.
  - Reads never skip beats.
- DONE:
  - m_pready=1 for exactly one cycle.
  - m_pslverr = accumulator. m_prdata = buffer; skipped or unused slices read as 0.
  - Return to IDLE.
- Slave errors do not abort the remaining beats. All beats are issued.
- Misaligned m_paddr is silently aligned. The master's low address bits are ignored.

## Timing
- Reset values:
  - s_psel, s_penable, s_pwrite, m_pready and m_pslverr are 0.
  - s_paddr, s_pwdata, s_pstrb and m_prdata are all zeros.
  - The FSM is in IDLE.
- Asserting PRESET mid-transfer drops s_psel at once. The slave transfer is abandoned and no m_pready is issued.
- Master setup is seen in cycle 0, so s_psel rises in cycle 1.
- With zero slave wait states, each beat takes 2 cycles. m_pready is high in cycle 1+2N, where N is the number of issued beats; RATIO=4 with a full read gives cycle 9.
- Each slave wait state adds 1 cycle.
- An all-zero-strobe write has m_pready in cycle 1 and no slave activity.
- m_pready is low in every cycle except DONE, which stalls the master access phase.
- A new master setup is accepted only in IDLE, the cycle after DONE. The master must not change signals while m_pready=0, per APB.
- s_pwrite, s_paddr, s_pwdata and s_pstrb are registered. They are stable from SETUP through the ACCESS cycle that completes the beat.

## Structure
- Package apb_downsizer_pkg holds:
  - the state enum (state_t)
  - the beat-index width function clog2_ratio
  - the lane-slice helper function.
- Sub-module apb_strb_scan is combinational. Inputs are the strobe vector and the current index; outputs are the next nonzero beat index and a valid flag. It is shared by IDLE (first beat) and ACCESS (next beat).
- Everything else stays in the top: FSM, capture registers, read buffer and error accumulator.

## Test plan
- Full write then read at 0x0040, DATAM=32, DATAS=8, data 0xA1B2C3D4, strobes 0xF, no waits:
  - Write: four slave writes with paddr 0x40..0x43 and data A1, B2, C3, D4.
  - Read: the slave returns the same bytes and m_prdata=0xA1B2C3D4. m_pready is in cycle 9 for each transfer.
- Write with strobe 0x5 (0b0101):
  - Only beats 1 and 3 are issued, at 0x41 and 0x43 with data B2 and D4.
  - m_pready is in cycle 5.
- Write with strobe 0x0: no s_psel. m_pready is in cycle 1 and m_pslverr=0.
- Read where the slave inserts 2 wait states on beat 2 and asserts s_pslverr on beat 1:
  - m_pready is in cycle 11 with m_pslverr=1.
  - All four beats are issued.
- PRESET asserted during the ACCESS of beat 1:
  - s_psel=0 and m_pready=0 immediately.
  - After release, a new transfer at 0x0080 completes normally.
- RATIO=1 (DATAM=DATAS=32):
  - A single slave beat with pass-through data 0xDEADBEEF.
  - m_pready is in cycle 3. The misaligned address 0x0083 is issued as 0x0080.

Source files
------------

// File: rtl/apb_downsizer_pkg.sv
// Shared types and helpers for the APB downsizing bridge.
package apb_downsizer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of the beat index; a single-beat bridge still needs one bit.
  function automatic int clog2_ratio(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // LSB of big-endian lane k in a vector of total_w bits split into lane_w lanes.
  // Lane 0 is the most-significant slice.
  function automatic int lane_lsb(input int total_w, input int lane_w, input int k);
    return total_w - (k + 1) * lane_w;
  endfunction

endpackage

// File: rtl/apb_strb_scan.sv
// Combinational search for the next beat whose strobe slice is nonzero.
module apb_strb_scan
  import apb_downsizer_pkg::*;
#(
  parameter int RATIO  = 4,
  parameter int LANE_W = 1,
  parameter int IDX_W  = 2
) (
  input  logic [RATIO*LANE_W-1:0] strb,
  input  logic [IDX_W-1:0]        idx,
  input  logic                    include_cur,
  output logic [IDX_W-1:0]        next_idx,
  output logic                    valid
);

  localparam int STRB_W = RATIO * LANE_W;

  // Walk from the top lane down so the lowest qualifying index wins.
  always_comb begin
    next_idx = '0;
    valid    = 1'b0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (((k > int'(idx)) || (include_cur && (k == int'(idx)))) &&
          (|strb[lane_lsb(STRB_W, LANE_W, k) +: LANE_W])) begin
        next_idx = IDX_W'(k);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_downsizer.sv
// Wide-to-narrow APB bridge: each master transfer becomes a run of slave beats.
module apb_downsizer
  import apb_downsizer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATAM_WIDTH = 32,
  parameter int DATAS_WIDTH = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     m_psel,
  input  logic                     m_penable,
  input  logic                     m_pwrite,
  input  logic [ADDR_WIDTH-1:0]    m_paddr,
  input  logic [DATAM_WIDTH-1:0]   m_pwdata,
  input  logic [DATAM_WIDTH/8-1:0] m_pstrb,
  output logic [DATAM_WIDTH-1:0]   m_prdata,
  output logic                     m_pready,
  output logic                     m_pslverr,
  output logic                     s_psel,
  output logic                     s_penable,
  output logic                     s_pwrite,
  output logic [ADDR_WIDTH-1:0]    s_paddr,
  output logic [DATAS_WIDTH-1:0]   s_pwdata,
  output logic [DATAS_WIDTH/8-1:0] s_pstrb,
  input  logic [DATAS_WIDTH-1:0]   s_prdata,
  input  logic                     s_pready,
  input  logic                     s_pslverr
);

  localparam int RATIO      = DATAM_WIDTH / DATAS_WIDTH;
  localparam int IDX_W      = clog2_ratio(RATIO);
  localparam int STRBM_W    = DATAM_WIDTH / 8;
  localparam int STRBS_W    = DATAS_WIDTH / 8;
  localparam int ALIGN_BITS = $clog2(STRBM_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

  state_t state_q, state_d;

  logic [IDX_W-1:0]       idx_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [DATAM_WIDTH-1:0] wdata_q;
  logic [STRBM_W-1:0]     strb_q;
  logic                   write_q;
  logic [DATAM_WIDTH-1:0] rbuf_q;
  logic                   err_q;

  logic                   start;
  logic                   beat_done;
  logic                   load_beat;

  logic [STRBM_W-1:0]     scan_strb;
  logic [IDX_W-1:0]       scan_idx;
  logic                   scan_incl;
  logic [IDX_W-1:0]       scan_next;
  logic                   scan_valid;

  logic [ADDR_WIDTH-1:0]  load_base;
  logic [DATAM_WIDTH-1:0] load_wdata;
  logic [STRBM_W-1:0]     load_strb;
  logic                   load_write;

  logic [ADDR_WIDTH-1:0]  beat_addr;
  logic [DATAS_WIDTH-1:0] beat_wdata;
  logic [STRBS_W-1:0]     beat_strb;

  assign start     = (state_q == IDLE) && m_psel && !m_penable;
  assign beat_done = (state_q == ACCESS) && s_pready;

  // In IDLE the scan looks at the live master strobes from beat 0; afterwards it
  // looks strictly above the current beat. Reads scan an all-ones mask so no beat is skipped.
  always_comb begin
    scan_strb = '1;
    scan_idx  = idx_q;
    scan_incl = 1'b0;
    if (state_q == IDLE) begin
      scan_idx  = '0;
      scan_incl = 1'b1;
      if (m_pwrite) scan_strb = m_pstrb;
    end else if (write_q) begin
      scan_strb = strb_q;
    end
  end

  apb_strb_scan #(
    .RATIO  (RATIO),
    .LANE_W (STRBS_W),
    .IDX_W  (IDX_W)
  ) u_scan (
    .strb        (scan_strb),
    .idx         (scan_idx),
    .include_cur (scan_incl),
    .next_idx    (scan_next),
    .valid       (scan_valid)
  );

  // The first beat is loaded straight from the master bus; later beats from the captured copy.
  always_comb begin
    load_base  = base_q;
    load_wdata = wdata_q;
    load_strb  = strb_q;
    load_write = write_q;
    if (state_q == IDLE) begin
      load_base  = m_paddr & ALIGN_MASK;
      load_wdata = m_pwdata;
      load_strb  = m_pstrb;
      load_write = m_pwrite;
    end
  end

  // Select address, data and strobe slice for the beat chosen by the scanner.
  always_comb begin
    beat_addr  = '0;
    beat_wdata = '0;
    beat_strb  = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (scan_next == IDX_W'(k)) begin
        beat_addr  = load_base + ADDR_WIDTH'(k * STRBS_W);
        beat_wdata = load_wdata[lane_lsb(DATAM_WIDTH, DATAS_WIDTH, k) +: DATAS_WIDTH];
        beat_strb  = load_write ? load_strb[lane_lsb(STRBM_W, STRBS_W, k) +: STRBS_W] : '0;
      end
    end
  end

  // Next-state logic; load_beat marks every transition into SETUP.
  always_comb begin
    state_d   = state_q;
    load_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (scan_valid) begin
            state_d   = SETUP;
            load_beat = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (s_pready) begin
          if (scan_valid) begin
            state_d   = SETUP;
            load_beat = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any slave transfer in flight.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the master request once, at the setup phase seen in IDLE.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      base_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      write_q  <= 1'b0;
      s_pwrite <= 1'b0;
    end else if (start) begin
      base_q   <= load_base;
      wdata_q  <= m_pwdata;
      strb_q   <= m_pstrb;
      write_q  <= m_pwrite;
      s_pwrite <= m_pwrite;
    end
  end

  // Beat registers hold steady from SETUP until the ACCESS cycle that completes the beat.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_q    <= '0;
      s_paddr  <= '0;
      s_pwdata <= '0;
      s_pstrb  <= '0;
    end else if (load_beat) begin
      idx_q    <= scan_next;
      s_paddr  <= beat_addr;
      s_pwdata <= beat_wdata;
      s_pstrb  <= beat_strb;
    end
  end

  // Reassemble read data into its big-endian slice and accumulate slave errors.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rbuf_q <= '0;
      err_q  <= 1'b0;
    end else if (start) begin
      rbuf_q <= '0;
      err_q  <= 1'b0;
    end else if (beat_done) begin
      err_q <= err_q | s_pslverr;
      for (int k = 0; k < RATIO; k++) begin
        if (!write_q && (idx_q == IDX_W'(k))) begin
          rbuf_q[lane_lsb(DATAM_WIDTH, DATAS_WIDTH, k) +: DATAS_WIDTH] <= s_prdata;
        end
      end
    end
  end

  assign s_psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign s_penable = (state_q == ACCESS);
  assign m_pready  = (state_q == DONE);
  assign m_pslverr = (state_q == DONE) && err_q;
  assign m_prdata  = rbuf_q;

endmodule

// File: tb/tb_apb_downsizer.sv
// Scoreboard bench for apb_downsizer: a 32->8 instance and a 32->32 pass-through instance.
module tb_apb_downsizer;

  typedef struct {
    logic [31:0] prdata;
    logic        err;
    int          start;
    int          lat;
  } m_exp_t;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [3:0]  strb;
  } s_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure transfer latency.
  always @(posedge clk) cycle++;

  // 32 -> 8 instance signals
  logic        a_m_psel, a_m_penable, a_m_pwrite;
  logic [12:0] a_m_paddr;
  logic [31:0] a_m_pwdata;
  logic [3:0]  a_m_pstrb;
  logic [31:0] a_m_prdata;
  logic        a_m_pready, a_m_pslverr;
  logic        a_s_psel, a_s_penable, a_s_pwrite;
  logic [12:0] a_s_paddr;
  logic [7:0]  a_s_pwdata;
  logic [0:0]  a_s_pstrb;
  logic [7:0]  a_s_prdata;
  logic        a_s_pready, a_s_pslverr;

  // 32 -> 32 instance signals
  logic        b_m_psel, b_m_penable, b_m_pwrite;
  logic [12:0] b_m_paddr;
  logic [31:0] b_m_pwdata;
  logic [3:0]  b_m_pstrb;
  logic [31:0] b_m_prdata;
  logic        b_m_pready, b_m_pslverr;
  logic        b_s_psel, b_s_penable, b_s_pwrite;
  logic [12:0] b_s_paddr;
  logic [31:0] b_s_pwdata;
  logic [3:0]  b_s_pstrb;
  logic [31:0] b_s_prdata;
  logic        b_s_pready, b_s_pslverr;

  m_exp_t a_mq[$];
  m_exp_t b_mq[$];
  s_exp_t a_sq[$];
  s_exp_t b_sq[$];
  m_exp_t a_me, b_me;
  s_exp_t a_se, b_se;

  logic [7:0] rd_bytes[4];
  int         waits[4];
  logic       errs[4];
  int         a_wait_cnt = 0;

  apb_downsizer #(.ADDR_WIDTH(13), .DATAM_WIDTH(32), .DATAS_WIDTH(8)) dut_a (
    .PCLK(clk), .PRESET(rst),
    .m_psel(a_m_psel), .m_penable(a_m_penable), .m_pwrite(a_m_pwrite),
    .m_paddr(a_m_paddr), .m_pwdata(a_m_pwdata), .m_pstrb(a_m_pstrb),
    .m_prdata(a_m_prdata), .m_pready(a_m_pready), .m_pslverr(a_m_pslverr),
    .s_psel(a_s_psel), .s_penable(a_s_penable), .s_pwrite(a_s_pwrite),
    .s_paddr(a_s_paddr), .s_pwdata(a_s_pwdata), .s_pstrb(a_s_pstrb),
    .s_prdata(a_s_prdata), .s_pready(a_s_pready), .s_pslverr(a_s_pslverr)
  );

  apb_downsizer #(.ADDR_WIDTH(13), .DATAM_WIDTH(32), .DATAS_WIDTH(32)) dut_b (
    .PCLK(clk), .PRESET(rst),
    .m_psel(b_m_psel), .m_penable(b_m_penable), .m_pwrite(b_m_pwrite),
    .m_paddr(b_m_paddr), .m_pwdata(b_m_pwdata), .m_pstrb(b_m_pstrb),
    .m_prdata(b_m_prdata), .m_pready(b_m_pready), .m_pslverr(b_m_pslverr),
    .s_psel(b_s_psel), .s_penable(b_s_penable), .s_pwrite(b_s_pwrite),
    .s_paddr(b_s_paddr), .s_pwdata(b_s_pwdata), .s_pstrb(b_s_pstrb),
    .s_prdata(b_s_prdata), .s_pready(b_s_pready), .s_pslverr(b_s_pslverr)
  );

  // Narrow slave model: per-byte-lane read data, wait states and error flags.
  always @(posedge clk) begin
    if (a_s_psel && a_s_penable && !a_s_pready) a_wait_cnt <= a_wait_cnt + 1;
    else                                         a_wait_cnt <= 0;
  end

  always_comb begin
    a_s_pready  = a_s_psel && a_s_penable && (a_wait_cnt >= waits[a_s_paddr[1:0]]);
    a_s_prdata  = rd_bytes[a_s_paddr[1:0]];
    a_s_pslverr = a_s_pready && errs[a_s_paddr[1:0]];
  end

  // Wide slave model: always ready, fixed read word.
  always_comb begin
    b_s_pready  = b_s_psel && b_s_penable;
    b_s_prdata  = 32'hDEADBEEF;
    b_s_pslverr = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushBeat(input logic [12:0] addr, input logic [31:0] data, input logic wr, input logic [3:0] strb);
    s_exp_t e;
    e.addr = addr; e.data = data; e.wr = wr; e.strb = strb;
    a_sq.push_back(e);
  endtask

  task automatic pushBeatB(input logic [12:0] addr, input logic [31:0] data, input logic wr, input logic [3:0] strb);
    s_exp_t e;
    e.addr = addr; e.data = data; e.wr = wr; e.strb = strb;
    b_sq.push_back(e);
  endtask

  // Master transfer on the 32->8 instance; the expected completion goes to the scoreboard.
  task automatic applyStimulus(input logic wr, input logic [12:0] addr, input logic [31:0] wd,
                               input logic [3:0] st, input logic [31:0] exp_rd,
                               input logic exp_err, input int exp_lat);
    m_exp_t e;
    @(negedge clk);
    a_m_psel = 1'b1; a_m_penable = 1'b0; a_m_pwrite = wr;
    a_m_paddr = addr; a_m_pwdata = wd; a_m_pstrb = st;
    e.prdata = exp_rd; e.err = exp_err; e.start = cycle; e.lat = exp_lat;
    a_mq.push_back(e);
    @(negedge clk);
    a_m_penable = 1'b1;
    for (int n = 0; n < 100 && !a_m_pready; n++) @(negedge clk);
    checkOutput("a_ready_seen", 32'(a_m_pready), 32'd1);
    @(negedge clk);
    a_m_psel = 1'b0; a_m_penable = 1'b0;
  endtask

  // Master transfer on the 32->32 instance.
  task automatic applyStimulusB(input logic wr, input logic [12:0] addr, input logic [31:0] wd,
                                input logic [3:0] st, input logic [31:0] exp_rd,
                                input logic exp_err, input int exp_lat);
    m_exp_t e;
    @(negedge clk);
    b_m_psel = 1'b1; b_m_penable = 1'b0; b_m_pwrite = wr;
    b_m_paddr = addr; b_m_pwdata = wd; b_m_pstrb = st;
    e.prdata = exp_rd; e.err = exp_err; e.start = cycle; e.lat = exp_lat;
    b_mq.push_back(e);
    @(negedge clk);
    b_m_penable = 1'b1;
    for (int n = 0; n < 100 && !b_m_pready; n++) @(negedge clk);
    checkOutput("b_ready_seen", 32'(b_m_pready), 32'd1);
    @(negedge clk);
    b_m_psel = 1'b0; b_m_penable = 1'b0;
  endtask

  // Master-side monitor: every m_pready pops one expected completion.
  always @(negedge clk) begin
    if (a_m_pready) begin
      if (a_mq.size() == 0) checkOutput("a_mq_nonempty", 32'(a_mq.size()), 32'd1);
      else begin
        a_me = a_mq.pop_front();
        checkOutput("a_prdata", a_m_prdata, a_me.prdata);
        checkOutput("a_pslverr", 32'(a_m_pslverr), 32'(a_me.err));
        checkOutput("a_latency", 32'(cycle - a_me.start), 32'(a_me.lat));
      end
    end
    if (b_m_pready) begin
      if (b_mq.size() == 0) checkOutput("b_mq_nonempty", 32'(b_mq.size()), 32'd1);
      else begin
        b_me = b_mq.pop_front();
        checkOutput("b_prdata", b_m_prdata, b_me.prdata);
        checkOutput("b_pslverr", 32'(b_m_pslverr), 32'(b_me.err));
        checkOutput("b_latency", 32'(cycle - b_me.start), 32'(b_me.lat));
      end
    end
  end

  // Slave-side monitor: every completed beat pops one expected beat.
  always @(negedge clk) begin
    if (a_s_psel && a_s_penable && a_s_pready) begin
      if (a_sq.size() == 0) checkOutput("a_sq_nonempty", 32'(a_sq.size()), 32'd1);
      else begin
        a_se = a_sq.pop_front();
        checkOutput("a_beat_addr", 32'(a_s_paddr), 32'(a_se.addr));
        checkOutput("a_beat_write", 32'(a_s_pwrite), 32'(a_se.wr));
        if (a_se.wr) begin
          checkOutput("a_beat_wdata", 32'(a_s_pwdata), a_se.data);
          checkOutput("a_beat_strb", 32'(a_s_pstrb), 32'(a_se.strb));
        end
      end
    end
    if (b_s_psel && b_s_penable && b_s_pready) begin
      if (b_sq.size() == 0) checkOutput("b_sq_nonempty", 32'(b_sq.size()), 32'd1);
      else begin
        b_se = b_sq.pop_front();
        checkOutput("b_beat_addr", 32'(b_s_paddr), 32'(b_se.addr));
        checkOutput("b_beat_write", 32'(b_s_pwrite), 32'(b_se.wr));
        if (b_se.wr) begin
          checkOutput("b_beat_wdata", b_s_pwdata, b_se.data);
          checkOutput("b_beat_strb", 32'(b_s_pstrb), 32'(b_se.strb));
        end
      end
    end
  end

  initial begin
    logic found;
    a_m_psel = 0; a_m_penable = 0; a_m_pwrite = 0; a_m_paddr = '0; a_m_pwdata = '0; a_m_pstrb = '0;
    b_m_psel = 0; b_m_penable = 0; b_m_pwrite = 0; b_m_paddr = '0; b_m_pwdata = '0; b_m_pstrb = '0;
    for (int i = 0; i < 4; i++) begin
      rd_bytes[i] = 8'h00; waits[i] = 0; errs[i] = 1'b0;
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_s_psel", 32'(a_s_psel), 32'd0);
    checkOutput("rst_s_penable", 32'(a_s_penable), 32'd0);
    checkOutput("rst_s_pwrite", 32'(a_s_pwrite), 32'd0);
    checkOutput("rst_m_pready", 32'(a_m_pready), 32'd0);
    checkOutput("rst_m_pslverr", 32'(a_m_pslverr), 32'd0);
    checkOutput("rst_s_paddr", 32'(a_s_paddr), 32'd0);
    checkOutput("rst_s_pwdata", 32'(a_s_pwdata), 32'd0);
    checkOutput("rst_s_pstrb", 32'(a_s_pstrb), 32'd0);
    checkOutput("rst_m_prdata", a_m_prdata, 32'd0);
    checkOutput("rst_b_s_psel", 32'(b_s_psel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full write: four beats, big-endian lanes.
    pushBeat(13'h040, 32'hA1, 1'b1, 4'h1);
    pushBeat(13'h041, 32'hB2, 1'b1, 4'h1);
    pushBeat(13'h042, 32'hC3, 1'b1, 4'h1);
    pushBeat(13'h043, 32'hD4, 1'b1, 4'h1);
    applyStimulus(1'b1, 13'h040, 32'hA1B2C3D4, 4'hF, 32'h0, 1'b0, 9);

    // Full read: bytes reassembled MSB first.
    rd_bytes[0] = 8'hA1; rd_bytes[1] = 8'hB2; rd_bytes[2] = 8'hC3; rd_bytes[3] = 8'hD4;
    pushBeat(13'h040, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h041, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h042, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h043, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 13'h040, 32'h0, 4'h0, 32'hA1B2C3D4, 1'b0, 9);

    // Misaligned read, error on beat 1, two waits on beat 2.
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    waits[2] = 2; errs[1] = 1'b1;
    pushBeat(13'h060, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h061, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h062, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h063, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 13'h062, 32'h0, 4'h0, 32'h11223344, 1'b1, 11);
    waits[2] = 0; errs[1] = 1'b0;

    // All-zero strobe write: no slave beats, error accumulator cleared.
    applyStimulus(1'b1, 13'h044, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1);

    // Sparse strobe 0101: only beats 1 and 3.
    pushBeat(13'h041, 32'hB2, 1'b1, 4'h1);
    pushBeat(13'h043, 32'hD4, 1'b1, 4'h1);
    applyStimulus(1'b1, 13'h040, 32'hA1B2C3D4, 4'h5, 32'h0, 1'b0, 5);

    // Reset during ACCESS of beat 1 of a read.
    waits[1] = 3;
    pushBeat(13'h040, 32'h0, 1'b0, 4'h0);
    @(negedge clk);
    a_m_psel = 1'b1; a_m_penable = 1'b0; a_m_pwrite = 1'b0; a_m_paddr = 13'h040; a_m_pstrb = 4'h0;
    @(negedge clk);
    a_m_penable = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (a_s_psel && a_s_penable && (a_s_paddr == 13'h041)) found = 1'b1;
    end
    checkOutput("reach_beat1_access", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_s_psel", 32'(a_s_psel), 32'd0);
    checkOutput("midrst_s_penable", 32'(a_s_penable), 32'd0);
    checkOutput("midrst_m_pready", 32'(a_m_pready), 32'd0);
    a_m_psel = 1'b0; a_m_penable = 1'b0;
    waits[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_beats_left", 32'(a_sq.size()), 32'd0);

    // Transfers after reset at 0x0080.
    pushBeat(13'h080, 32'h01, 1'b1, 4'h1);
    pushBeat(13'h081, 32'h02, 1'b1, 4'h1);
    pushBeat(13'h082, 32'h03, 1'b1, 4'h1);
    pushBeat(13'h083, 32'h04, 1'b1, 4'h1);
    applyStimulus(1'b1, 13'h080, 32'h01020304, 4'hF, 32'h0, 1'b0, 9);
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'h6B; rd_bytes[2] = 8'h7C; rd_bytes[3] = 8'h8D;
    pushBeat(13'h080, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h081, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h082, 32'h0, 1'b0, 4'h0);
    pushBeat(13'h083, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 13'h080, 32'h0, 4'h0, 32'h5A6B7C8D, 1'b0, 9);

    // Pass-through instance: misaligned 0x0083 issued as 0x0080.
    pushBeatB(13'h080, 32'h0, 1'b0, 4'h0);
    applyStimulusB(1'b0, 13'h083, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3);
    pushBeatB(13'h080, 32'hCAFEF00D, 1'b1, 4'hF);
    applyStimulusB(1'b1, 13'h083, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3);

    repeat (4) @(negedge clk);
    checkOutput("a_mq_drained", 32'(a_mq.size()), 32'd0);
    checkOutput("a_sq_drained", 32'(a_sq.size()), 32'd0);
    checkOutput("b_mq_drained", 32'(b_mq.size()), 32'd0);
    checkOutput("b_sq_drained", 32'(b_sq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
